// File: rtl/ppl_ray_scheduler_pkg.sv
// Shared definitions for the ray-march entry scheduler.
// Holds the frame FSM state encoding, the default step limit and the common field widths.
package ppl_ray_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned MAX_STEPS_DEF = 31;
  localparam int unsigned PIX_ADDR_W    = 20;
  localparam int unsigned STEP_W        = 5;
  localparam int unsigned POSE_W        = 16;

endpackage

// File: rtl/ppl_ray_scheduler_if.sv
// Signal bundle between the ray scheduler and its surroundings: the display/frame side,
// the camera pose source, the pipeline tail, the pipeline entry mux and the frame-buffer
// writer.
//   master : environment view (drives frame_req, cam_*, tail ray fields)
//   slave  : scheduler view (drives pose, entry control, write port, status)
interface ppl_ray_scheduler_if;
  import ppl_ray_scheduler_pkg::*;

  logic                  frame_req;
  logic [POSE_W-1:0]     cam_pos_x;
  logic [POSE_W-1:0]     cam_pos_y;
  logic [POSE_W-1:0]     cam_pos_z;
  logic [POSE_W-1:0]     cam_angle_x;
  logic [POSE_W-1:0]     cam_angle_y;
  logic                  out_hit;
  logic [STEP_W-1:0]     block_cnt_out;
  logic [PIX_ADDR_W-1:0] pixel_addr_out;

  logic [POSE_W-1:0]     p_pos_x;
  logic [POSE_W-1:0]     p_pos_y;
  logic [POSE_W-1:0]     p_pos_z;
  logic [POSE_W-1:0]     p_angle_x;
  logic [POSE_W-1:0]     p_angle_y;
  logic                  next_en;
  logic                  scanner_stop;
  logic                  pix_wr_en;
  logic [PIX_ADDR_W-1:0] pix_wr_addr;
  logic                  pix_wr_hit;
  logic [STEP_W-1:0]     pix_wr_steps;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output frame_req, cam_pos_x, cam_pos_y, cam_pos_z, cam_angle_x, cam_angle_y,
    output out_hit, block_cnt_out, pixel_addr_out,
    input  p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y,
    input  next_en, scanner_stop, pix_wr_en, pix_wr_addr, pix_wr_hit, pix_wr_steps,
    input  busy, frame_done
  );

  modport slave (
    input  frame_req, cam_pos_x, cam_pos_y, cam_pos_z, cam_angle_x, cam_angle_y,
    input  out_hit, block_cnt_out, pixel_addr_out,
    output p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y,
    output next_en, scanner_stop, pix_wr_en, pix_wr_addr, pix_wr_hit, pix_wr_steps,
    output busy, frame_done
  );

endinterface

// File: rtl/ppl_slot_tracker.sv
// Pipeline slot-valid ring. One bit per pipeline stage; a bit enters at the entry slot and
// emerges DEPTH cycles later as tail_valid.
//   clk, rst   : clock, synchronous active-high reset (clears all slots)
//   occupy     : entry slot receives a ray this cycle (new or recirculated)
//   tail_valid : the ray at the pipeline tail is real, not a bubble
module ppl_slot_tracker #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic occupy,
  output logic tail_valid
);

  logic [DEPTH-1:0] ring_q;
  logic [DEPTH-1:0] ring_d;

  always_comb begin
    ring_d = {ring_q[DEPTH-2:0], occupy};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q <= '0;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign tail_valid = ring_q[DEPTH-1];

endmodule

// File: rtl/ppl_ray_scheduler.sv
// Frame-level sequencer for the ray-march pipeline entry.
// Each cycle picks what enters the pipeline: the tail ray (recirculate), a new scanner ray,
// or a bubble. Finished tail rays are written to the frame buffer one cycle later. Camera
// pose is latched once at frame acceptance.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ppl_ray_scheduler_if.slave (frame handshake, pose, tail ray, entry control,
//              frame-buffer write port, busy/frame_done status)
module ppl_ray_scheduler
  import ppl_ray_scheduler_pkg::*;
#(
  parameter int unsigned H_DISP    = 1280,
  parameter int unsigned V_DISP    = 720,
  parameter int unsigned PPL_DEPTH = 8,
  parameter int unsigned MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  ppl_ray_scheduler_if.slave  bus
);

  localparam logic [PIX_ADDR_W-1:0] TotalPix  = PIX_ADDR_W'(H_DISP * V_DISP);
  localparam logic [STEP_W-1:0]     StepLimit = STEP_W'(MAX_STEPS);

  state_e                state_q, state_d;
  logic [PIX_ADDR_W-1:0] issued_q, issued_d;
  logic [PIX_ADDR_W-1:0] retired_q, retired_d;
  logic                  latch_pose;

  logic [POSE_W-1:0]     pos_x_q, pos_y_q, pos_z_q, ang_x_q, ang_y_q;
  logic                  wr_en_q, wr_hit_q;
  logic [PIX_ADDR_W-1:0] wr_addr_q;
  logic [STEP_W-1:0]     wr_steps_q;

  logic tail_valid, retire, recirc, issue, occupy;

  ppl_slot_tracker #(
    .DEPTH (PPL_DEPTH)
  ) u_slot_tracker (
    .clk        (clk),
    .rst        (rst),
    .occupy     (occupy),
    .tail_valid (tail_valid)
  );

  // Entry decode: an unfinished tail ray always has priority over the scanner.
  always_comb begin
    retire = tail_valid && (bus.out_hit || (bus.block_cnt_out >= StepLimit));
    recirc = tail_valid && !retire;
    issue  = !recirc && (state_q == StFill) && (issued_q < TotalPix);
    occupy = recirc || issue;
  end

  assign bus.next_en      = ~recirc;
  assign bus.scanner_stop = ~issue;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    retired_d  = retired_q;
    latch_pose = 1'b0;
    if (issue) begin
      issued_d = issued_q + PIX_ADDR_W'(1);
    end
    if (retire) begin
      retired_d = retired_q + PIX_ADDR_W'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (bus.frame_req) begin
          state_d    = StFill;
          latch_pose = 1'b1;
          issued_d   = '0;
          retired_d  = '0;
        end
      end
      StFill: begin
        if (issued_q == TotalPix) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // retired_q reaches the total on the same edge the last write strobe is registered,
        // so frame_done follows the final write by one cycle.
        if (retired_q == TotalPix) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      pos_z_q <= '0;
      ang_x_q <= '0;
      ang_y_q <= '0;
    end else if (latch_pose) begin
      pos_x_q <= bus.cam_pos_x;
      pos_y_q <= bus.cam_pos_y;
      pos_z_q <= bus.cam_pos_z;
      ang_x_q <= bus.cam_angle_x;
      ang_y_q <= bus.cam_angle_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_hit_q   <= 1'b0;
      wr_steps_q <= '0;
    end else begin
      wr_en_q <= retire;
      if (retire) begin
        wr_addr_q  <= bus.pixel_addr_out;
        wr_hit_q   <= bus.out_hit;
        wr_steps_q <= bus.block_cnt_out;
      end
    end
  end

  assign bus.p_pos_x      = pos_x_q;
  assign bus.p_pos_y      = pos_y_q;
  assign bus.p_pos_z      = pos_z_q;
  assign bus.p_angle_x    = ang_x_q;
  assign bus.p_angle_y    = ang_y_q;
  assign bus.pix_wr_en    = wr_en_q;
  assign bus.pix_wr_addr  = wr_addr_q;
  assign bus.pix_wr_hit   = wr_hit_q;
  assign bus.pix_wr_steps = wr_steps_q;
  assign bus.busy         = (state_q == StFill) || (state_q == StDrain);
  assign bus.frame_done   = (state_q == StDone);

endmodule

// File: tb/tb_ppl_ray_scheduler.sv
// Bench for ppl_ray_scheduler: a behavioural pipeline/scanner environment plus per-pixel
// expected results derived from each pixel's "hit on pass k" value.
module tb_ppl_ray_scheduler;
  import ppl_ray_scheduler_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int D  = 3;
  localparam int MS = 4;
  localparam int N  = H * V;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppl_ray_scheduler_if bus ();

  ppl_ray_scheduler #(
    .H_DISP    (H),
    .V_DISP    (V),
    .PPL_DEPTH (D),
    .MAX_STEPS (MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit v;
    int addr;
    int steps;
  } ray_t;

  typedef struct {
    int hit_at;
    bit exp_hit;
    int exp_steps;
  } vec_t;

  int total = 0;
  int bad = 0;

  ray_t        pipe[D];
  int          hit_at[N];
  bit          written[N];
  bit          got_hit[N];
  int          got_steps[N];
  int          wr_order[N];
  int          scan_pos, issued_m, writes_m, done_cnt, win, last_wr_win;
  bit          filling, idle_m, prev_ret, prev_hit, cam_rand;
  ray_t        prev;
  logic [79:0] exp_pose;
  vec_t        tbl[N];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) pipe[i] = '{v: 1'b0, addr: 0, steps: 0};
    scan_pos    = 0;
    issued_m    = 0;
    writes_m    = 0;
    filling     = 1'b0;
    idle_m      = 1'b1;
    prev_ret    = 1'b0;
    prev_hit    = 1'b0;
    prev        = '{v: 1'b0, addr: 0, steps: 0};
    last_wr_win = -10;
    exp_pose    = '0;
  endtask

  // One clock of environment: drive tail, check DUT decision, advance the pipeline model.
  task automatic cycle();
    ray_t tail, entry;
    bit   hit_m, ret, exp_done;
    tail = pipe[D-1];
    if (cam_rand) begin
      bus.cam_pos_x   = 16'($urandom);
      bus.cam_pos_y   = 16'($urandom);
      bus.cam_pos_z   = 16'($urandom);
      bus.cam_angle_x = 16'($urandom);
      bus.cam_angle_y = 16'($urandom);
    end
    hit_m = tail.v && (tail.steps == hit_at[tail.addr]);
    if (tail.v) begin
      bus.out_hit        = hit_m;
      bus.block_cnt_out  = 5'(tail.steps);
      bus.pixel_addr_out = 20'(tail.addr);
    end else begin
      bus.out_hit        = 1'($urandom);
      bus.block_cnt_out  = 5'($urandom);
      bus.pixel_addr_out = 20'($urandom);
    end
    #1;
    ret = tail.v && (hit_m || tail.steps >= MS);
    chk("next_en", bus.next_en, (tail.v && !ret) ? 1'b0 : 1'b1);
    if (bus.next_en)
      chk("scanner_stop", bus.scanner_stop, (filling && issued_m < N) ? 1'b0 : 1'b1);
    exp_done = !idle_m && writes_m == N && last_wr_win == win - 1;
    chk("frame_done", bus.frame_done, exp_done);
    chk("busy", bus.busy, !idle_m && !exp_done);
    chk("pose", {bus.p_pos_x, bus.p_pos_y, bus.p_pos_z, bus.p_angle_x, bus.p_angle_y},
        exp_pose);
    chk("pix_wr_en", bus.pix_wr_en, prev_ret);
    if (bus.frame_done) done_cnt++;
    if (bus.pix_wr_en && prev_ret) begin
      chk("pix_wr_addr", bus.pix_wr_addr, prev.addr);
      chk("pix_wr_hit", bus.pix_wr_hit, prev_hit);
      chk("pix_wr_steps", bus.pix_wr_steps, prev.steps);
      chk("dup_write", written[prev.addr], 1'b0);
      written[prev.addr]   = 1'b1;
      got_hit[prev.addr]   = bus.pix_wr_hit;
      got_steps[prev.addr] = int'(bus.pix_wr_steps);
      if (writes_m < N) wr_order[writes_m] = int'(bus.pix_wr_addr);
      writes_m++;
      last_wr_win = win;
    end
    if (!bus.next_en) begin
      entry = '{v: 1'b1, addr: tail.addr, steps: tail.steps + 1};
    end else if (!bus.scanner_stop) begin
      entry = '{v: 1'b1, addr: scan_pos, steps: 0};
      scan_pos = (scan_pos + 1) % N;
      issued_m++;
    end else begin
      entry = '{v: 1'b0, addr: 0, steps: 0};
    end
    prev_ret = ret;
    prev     = tail;
    prev_hit = hit_m;
    for (int i = D - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = entry;
    if (issued_m >= N) filling = 1'b0;
    if (idle_m && bus.frame_req) begin
      idle_m   = 1'b0;
      filling  = 1'b1;
      issued_m = 0;
      writes_m = 0;
      for (int i = 0; i < N; i++) written[i] = 1'b0;
      exp_pose = {bus.cam_pos_x, bus.cam_pos_y, bus.cam_pos_z, bus.cam_angle_x,
                  bus.cam_angle_y};
    end
    if (exp_done) idle_m = 1'b1;
    win++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int poke_at, input int cam_change_at);
    int n, done_before;
    done_before = done_cnt;
    bus.frame_req = 1'b1;
    cycle();
    bus.frame_req = 1'b0;
    n = 0;
    while (!idle_m && n < 300) begin
      if (n == poke_at) bus.frame_req = 1'b1;
      if (n == cam_change_at) bus.cam_pos_x = 16'h2000;
      cycle();
      bus.frame_req = 1'b0;
      n++;
    end
    chk("frame_timeout", idle_m, 1'b1);
    chk("issues", issued_m, N);
    chk("writes", writes_m, N);
    chk("done_count", done_cnt - done_before, 1);
  endtask

  task automatic check_pixels_formula();
    for (int i = 0; i < N; i++) begin
      chk("px_hit", got_hit[i], hit_at[i] <= MS);
      chk("px_steps", got_steps[i], (hit_at[i] < MS) ? hit_at[i] : MS);
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_next_en", bus.next_en, 1'b1);
    chk("rst_scanner_stop", bus.scanner_stop, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pix_wr_en", bus.pix_wr_en, 1'b0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_pose", {bus.p_pos_x, bus.p_pos_y, bus.p_pos_z, bus.p_angle_x, bus.p_angle_y},
        80'h0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{hit_at: 0, exp_hit: 1'b1, exp_steps: 0};
    tbl[1] = '{hit_at: 1, exp_hit: 1'b1, exp_steps: 1};
    tbl[2] = '{hit_at: 3, exp_hit: 1'b1, exp_steps: 3};
    tbl[3] = '{hit_at: 4, exp_hit: 1'b1, exp_steps: 4};
    tbl[4] = '{hit_at: 5, exp_hit: 1'b0, exp_steps: 4};
    tbl[5] = '{hit_at: 7, exp_hit: 1'b0, exp_steps: 4};
    tbl[6] = '{hit_at: 2, exp_hit: 1'b1, exp_steps: 2};
    tbl[7] = '{hit_at: 6, exp_hit: 1'b0, exp_steps: 4};

    done_cnt = 0;
    win      = 0;
    cam_rand = 1'b1;
    bus.frame_req      = 1'b0;
    bus.cam_pos_x      = 16'h0;
    bus.cam_pos_y      = 16'h0;
    bus.cam_pos_z      = 16'h0;
    bus.cam_angle_x    = 16'h0;
    bus.cam_angle_y    = 16'h0;
    bus.out_hit        = 1'b0;
    bus.block_cnt_out  = 5'd0;
    bus.pixel_addr_out = 20'd0;
    for (int i = 0; i < N; i++) hit_at[i] = 0;
    @(negedge clk);
    apply_reset(2);
    repeat (3) cycle();

    // Instant hit: every ray retires on its first pass, in scan order.
    for (int i = 0; i < N; i++) hit_at[i] = 0;
    run_frame(-1, -1);
    for (int i = 0; i < N; i++) chk("instant_order", wr_order[i], i);
    repeat (2) cycle();

    // Table: hit pass per pixel vs expected retired hit/steps (step limit included).
    for (int i = 0; i < N; i++) hit_at[i] = tbl[i].hit_at;
    run_frame(-1, -1);
    for (int i = 0; i < N; i++) begin
      chk("tbl_hit", got_hit[i], tbl[i].exp_hit);
      chk("tbl_steps", got_steps[i], tbl[i].exp_steps);
    end
    repeat (2) cycle();

    // Pose latch held across a mid-frame camera change, plus an ignored request in FILL.
    cam_rand = 1'b0;
    bus.cam_pos_x = 16'h1000;
    for (int i = 0; i < N; i++) hit_at[i] = i % 3;
    run_frame(2, 4);
    chk("pose_hold", bus.p_pos_x, 16'h1000);
    repeat (3) cycle();
    chk("pose_idle", bus.p_pos_x, 16'h1000);
    run_frame(-1, -1);
    chk("pose_new", bus.p_pos_x, 16'h2000);
    cam_rand = 1'b1;
    repeat (2) cycle();

    // Mid-frame reset after three issues, then a clean frame.
    for (int i = 0; i < N; i++) hit_at[i] = 2;
    bus.frame_req = 1'b1;
    cycle();
    bus.frame_req = 1'b0;
    for (int n = 0; n < 20 && issued_m < 3; n++) cycle();
    chk("three_issued", issued_m, 3);
    apply_reset(1);
    repeat (6) cycle();
    run_frame(-1, -1);
    check_pixels_formula();
    repeat (2) cycle();

    // Randomised frames with random hit passes and stray requests while busy.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) hit_at[i] = int'($urandom_range(0, 6));
      run_frame(int'($urandom_range(0, 12)), -1);
      check_pixels_formula();
      repeat (int'($urandom_range(0, 3))) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
